// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer for two requesters in front of a single-port synchronous RAM.
// One access per cycle; read data returns exactly one cycle after the read grant.
module ram_arbiter #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  res,
   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [WIDTH-1:0]      m0_wdata,
   output logic                  m0_gnt,
   output logic                  m0_rvalid,
   output logic [WIDTH-1:0]      m0_rdata,
   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [WIDTH-1:0]      m1_wdata,
   output logic                  m1_gnt,
   output logic                  m1_rvalid,
   output logic [WIDTH-1:0]      m1_rdata,
   output logic                  ram_re,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [WIDTH-1:0]      ram_din,
   input  logic [WIDTH-1:0]      ram_dout
);

   logic rd_pend_q, rd_pend_d;
   logic rd_owner_q, rd_owner_d;
   logic last_gnt_q, last_gnt_d;
   logic gnt0, gnt1, any_gnt, sel_we;

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         rd_pend_q  <= 1'b0;
         rd_owner_q <= 1'b0;
         last_gnt_q <= 1'b1;
      end else begin
         rd_pend_q  <= rd_pend_d;
         rd_owner_q <= rd_owner_d;
         last_gnt_q <= last_gnt_d;
      end
   end

   always_comb begin
      // Gating with res forces every handshake output low while reset is held.
      gnt0     = res & m0_req & (~m1_req | last_gnt_q);
      gnt1     = res & m1_req & (~m0_req | ~last_gnt_q);
      any_gnt  = gnt0 | gnt1;
      sel_we   = gnt1 ? m1_we : m0_we;

      ram_addr = '0;
      ram_din  = '0;
      if (gnt0) begin
         ram_addr = m0_addr;
         ram_din  = m0_we ? m0_wdata : '0;
      end else if (gnt1) begin
         ram_addr = m1_addr;
         ram_din  = m1_we ? m1_wdata : '0;
      end
      ram_we = any_gnt & sel_we;
      ram_re = any_gnt & ~sel_we;

      m0_gnt    = gnt0;
      m1_gnt    = gnt1;
      m0_rvalid = res & rd_pend_q & ~rd_owner_q;
      m1_rvalid = res & rd_pend_q & rd_owner_q;
      m0_rdata  = ram_dout;
      m1_rdata  = ram_dout;

      last_gnt_d = any_gnt ? gnt1 : last_gnt_q;
      rd_pend_d  = any_gnt & ~sel_we;
      rd_owner_d = rd_pend_d ? gnt1 : rd_owner_q;
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural single-port RAM (registered read address).
module tb_ram_arbiter;

   localparam int W  = 32;
   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          res;
   logic          m0_req, m0_we, m1_req, m1_we;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [W-1:0]  m0_wdata, m1_wdata;
   logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [W-1:0]  m0_rdata, m1_rdata;
   logic          ram_re, ram_we;
   logic [AW-1:0] ram_addr;
   logic [W-1:0]  ram_din, ram_dout;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] mem [0:255];
   logic [7:0]   ram_aq = 8'd0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr[7:0]] <= ram_din;
      if (ram_re) ram_aq <= ram_addr[7:0];
   end
   assign ram_dout = mem[ram_aq];

   ram_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .res(res),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .ram_re(ram_re), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
      .ram_dout(ram_dout)
   );

   task automatic idle();
      @(negedge clk);
      m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
      m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
      #1;
   endtask

   task automatic test_reset_read();
      res = 0; m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
      m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
      #2;
      total++;
      if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_re, ram_we} !== 6'b0) begin
         bad++; $display("FAIL reset_outs got=%b want=000000",
                         {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_re, ram_we});
      end
      @(negedge clk); res = 1;
      @(negedge clk);
      m0_req = 1; m0_addr = 32'h10; #1;
      total++;
      if ({m0_gnt, m1_gnt, ram_re, ram_we} !== 4'b1010 || ram_addr !== 32'h10) begin
         bad++; $display("FAIL rd0_grant gnt0/gnt1/re/we=%b addr=%h want 1010 addr=10",
                         {m0_gnt, m1_gnt, ram_re, ram_we}, ram_addr);
      end
      @(negedge clk); m0_req = 0; #1;
      total++;
      if (m0_rvalid !== 1 || m0_rdata !== 32'hDEADBEEF || m1_rvalid !== 0 || m1_gnt !== 0) begin
         bad++; $display("FAIL rd0_return rv0=%b rd=%h rv1=%b gnt1=%b want 1 deadbeef 0 0",
                         m0_rvalid, m0_rdata, m1_rvalid, m1_gnt);
      end
      idle();
   endtask

   task automatic test_write_read();
      @(negedge clk);
      m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h12345678; #1;
      total++;
      if (m1_gnt !== 1 || ram_we !== 1 || ram_re !== 0 || ram_din !== 32'h12345678 || ram_addr !== 32'h20) begin
         bad++; $display("FAIL wr1 gnt=%b we=%b re=%b din=%h addr=%h want 1 1 0 12345678 20",
                         m1_gnt, ram_we, ram_re, ram_din, ram_addr);
      end
      @(negedge clk); m1_we = 0; m1_wdata = '0; #1;
      total++;
      if (m1_gnt !== 1 || ram_re !== 1 || ram_we !== 0 || m1_rvalid !== 0) begin
         bad++; $display("FAIL rd1_after_wr gnt=%b re=%b we=%b rv=%b want 1 1 0 0",
                         m1_gnt, ram_re, ram_we, m1_rvalid);
      end
      @(negedge clk); m1_req = 0; #1;
      total++;
      if (m1_rvalid !== 1 || m1_rdata !== 32'h12345678 || m0_rvalid !== 0) begin
         bad++; $display("FAIL wr_rd_data rv=%b rd=%h rv0=%b want 1 12345678 0",
                         m1_rvalid, m1_rdata, m0_rvalid);
      end
      idle();
   endtask

   // last_gnt is 1 here (m1 granted last), so contention starts with m0.
   task automatic test_round_robin();
      logic [W-1:0] d [0:1];
      d[0] = 32'h0000_0444; d[1] = 32'h0000_0888;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         m0_req = 1; m0_addr = 32'h4; m1_req = 1; m1_addr = 32'h8; #1;
         total++;
         if (m0_gnt !== (i % 2 == 0) || m1_gnt !== (i % 2 == 1) || ram_re !== 1 || ram_we !== 0) begin
            bad++; $display("FAIL rr_grant[%0d] gnt0=%b gnt1=%b re=%b we=%b want %b %b 1 0",
                            i, m0_gnt, m1_gnt, ram_re, ram_we, i % 2 == 0, i % 2 == 1);
         end
         if (i > 0) begin
            total++;
            if (m0_rvalid !== (i % 2 == 1) || m1_rvalid !== (i % 2 == 0) ||
                (i % 2 == 1 && m0_rdata !== d[0]) || (i % 2 == 0 && m1_rdata !== d[1])) begin
               bad++; $display("FAIL rr_rvalid[%0d] rv0=%b rd0=%h rv1=%b rd1=%h",
                               i, m0_rvalid, m0_rdata, m1_rvalid, m1_rdata);
            end
         end
      end
      @(negedge clk); m0_req = 0; m1_req = 0; #1;
      total++;
      if (m1_rvalid !== 1 || m1_rdata !== d[1] || m0_rvalid !== 0) begin
         bad++; $display("FAIL rr_tail rv1=%b rd1=%h rv0=%b want 1 00000888 0",
                         m1_rvalid, m1_rdata, m0_rvalid);
      end
      idle();
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] a [0:3];
      logic [W-1:0]  d [0:3];
      a[0] = 32'h4; a[1] = 32'h8; a[2] = 32'h10; a[3] = 32'h20;
      d[0] = 32'h444; d[1] = 32'h888; d[2] = 32'hDEADBEEF; d[3] = 32'h12345678;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         m1_req = (i < 4); m1_addr = (i < 4) ? a[i] : '0; #1;
         total++;
         if (m1_gnt !== (i < 4) || ram_we !== 0 || m0_gnt !== 0 ||
             m1_rvalid !== (i > 0) || (i > 0 && m1_rdata !== d[(i + 3) % 4])) begin
            bad++; $display("FAIL b2b[%0d] gnt1=%b we=%b gnt0=%b rv1=%b rd1=%h",
                            i, m1_gnt, ram_we, m0_gnt, m1_rvalid, m1_rdata);
         end
      end
      idle();
   endtask

   task automatic test_wr_rd_collision();
      @(negedge clk); m0_req = 1; m0_addr = 32'h4; #1;
      total++;
      if (m0_gnt !== 1) begin bad++; $display("FAIL col_setup gnt0=%b want 1", m0_gnt); end
      // last_gnt is now 0: m1 must win the next contention.
      @(negedge clk);
      m0_we = 1; m0_addr = 32'h30; m0_wdata = 32'hCAFEF00D;
      m1_req = 1; m1_addr = 32'h8; #1;
      total++;
      if (m1_gnt !== 1 || m0_gnt !== 0 || ram_re !== 1 || ram_we !== 0 || ram_addr !== 32'h8 ||
          m0_rvalid !== 1 || m0_rdata !== 32'h444) begin
         bad++; $display("FAIL col_m1 gnt1=%b gnt0=%b re=%b we=%b addr=%h rv0=%b rd0=%h",
                         m1_gnt, m0_gnt, ram_re, ram_we, ram_addr, m0_rvalid, m0_rdata);
      end
      @(negedge clk); m1_req = 0; #1;
      total++;
      if (m0_gnt !== 1 || ram_we !== 1 || ram_re !== 0 || ram_din !== 32'hCAFEF00D ||
          ram_addr !== 32'h30 || m1_rvalid !== 1 || m1_rdata !== 32'h888) begin
         bad++; $display("FAIL col_m0 gnt0=%b we=%b re=%b din=%h addr=%h rv1=%b rd1=%h",
                         m0_gnt, ram_we, ram_re, ram_din, ram_addr, m1_rvalid, m1_rdata);
      end
      @(negedge clk); m0_req = 0; m0_we = 0; #1;
      total++;
      if (m0_rvalid !== 0 || m1_rvalid !== 0 || mem[8'h30] !== 32'hCAFEF00D) begin
         bad++; $display("FAIL col_after rv0=%b rv1=%b mem30=%h want 0 0 cafef00d",
                         m0_rvalid, m1_rvalid, mem[8'h30]);
      end
      idle();
   endtask

   task automatic test_reset_midflight();
      @(negedge clk); m0_req = 1; m0_addr = 32'h10; #1;
      total++;
      if (m0_gnt !== 1) begin bad++; $display("FAIL mid_grant gnt0=%b want 1", m0_gnt); end
      @(negedge clk); m1_req = 1; m1_addr = 32'h8; #1;
      total++;
      if (m0_rvalid !== 1) begin bad++; $display("FAIL mid_rvalid rv0=%b want 1", m0_rvalid); end
      res = 0; #1;
      total++;
      if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_re, ram_we} !== 6'b0) begin
         bad++; $display("FAIL mid_reset_outs got=%b want=000000",
                         {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_re, ram_we});
      end
      @(negedge clk); res = 1; #1;
      total++;
      if (m0_gnt !== 1 || m1_gnt !== 0 || m0_rvalid !== 0 || m1_rvalid !== 0) begin
         bad++; $display("FAIL post_reset gnt0=%b gnt1=%b rv0=%b rv1=%b want 1 0 0 0",
                         m0_gnt, m1_gnt, m0_rvalid, m1_rvalid);
      end
      idle();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[8'h04] = 32'h0000_0444;
      mem[8'h08] = 32'h0000_0888;
      mem[8'h10] = 32'hDEADBEEF;
      test_reset_read();
      test_write_read();
      test_round_robin();
      test_back_to_back();
      test_wr_rd_collision();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
